// File: rtl/platform_array_pkg.sv
// Shared constants, gadget codes and lookup tables for the platform array.
package platform_array_pkg;

    localparam int unsigned GADGET_BIT_CNT = 4;
    localparam int unsigned SIZE_LVL_W     = 3;
    localparam int unsigned SPEED_W        = 3;
    localparam int unsigned BALL_LVL_W     = 2;
    localparam int unsigned PLAT_SIZE_W    = 8;
    localparam int unsigned BALL_SIZE_W    = 6;

    localparam int unsigned WALL_THICKNESS = 8;
    localparam int unsigned SCREEN_W       = 640;
    localparam int unsigned PLAT_PIXELY    = 460;
    localparam int unsigned RESET_X        = 320;

    localparam logic [SIZE_LVL_W-1:0] SIZE_LVL_RST  = 3'd3;
    localparam logic [SIZE_LVL_W-1:0] SIZE_LVL_MIN  = 3'd2;
    localparam logic [SIZE_LVL_W-1:0] SIZE_LVL_MAX  = 3'd5;
    localparam logic [SPEED_W-1:0]    SPEED_RST     = 3'd3;
    localparam logic [SPEED_W-1:0]    SPEED_MIN     = 3'd2;
    localparam logic [SPEED_W-1:0]    SPEED_MAX     = 3'd5;
    localparam logic [BALL_LVL_W-1:0] BALL_LVL_RST  = 2'd2;
    localparam logic [BALL_LVL_W-1:0] BALL_LVL_MIN  = 2'd1;
    localparam logic [BALL_LVL_W-1:0] BALL_LVL_MAX  = 2'd3;

    // Codes 8..15 are not assigned and are ignored by the channels.
    typedef enum logic [GADGET_BIT_CNT-1:0] {
        GadgetExpand      = 4'd0,
        GadgetShrink      = 4'd1,
        GadgetGrab        = 4'd2,
        GadgetFasterBall  = 4'd3,
        GadgetSlowerBall  = 4'd4,
        GadgetFireBall    = 4'd5,
        GadgetBiggerBall  = 4'd6,
        GadgetSmallerBall = 4'd7
    } gadget_e;

    function automatic logic [PLAT_SIZE_W-1:0] plat_half(input logic [SIZE_LVL_W-1:0] lvl);
        logic [PLAT_SIZE_W-1:0] half;
        case (lvl)
            3'd1:    half = 8'd8;
            3'd2:    half = 8'd16;
            3'd4:    half = 8'd64;
            3'd5:    half = 8'd128;
            default: half = 8'd32;
        endcase
        return half;
    endfunction

    function automatic logic [BALL_SIZE_W-1:0] ball_radius(input logic [BALL_LVL_W-1:0] lvl);
        logic [BALL_SIZE_W-1:0] rad;
        case (lvl)
            2'd1:    rad = 6'd3;
            2'd3:    rad = 6'd7;
            default: rad = 6'd5;
        endcase
        return rad;
    endfunction

endpackage

// File: rtl/platform_channel.sv
// One platform: position handshake, size/speed/ball levels and timed gadget flags.
module platform_channel
    import platform_array_pkg::*;
#(
    parameter int unsigned X_W           = 10,
    parameter int unsigned EFFECT_FRAMES = 600,
    parameter int unsigned MAX_STEP      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_game_start,
    input  logic                      i_cal_frame,
    input  logic [X_W-1:0]            i_gamepad_x,
    input  logic                      i_req,
    output logic                      o_ack,
    output logic [X_W-1:0]            o_x,
    output logic [PLAT_SIZE_W-1:0]    o_size,
    input  logic                      i_catch,
    input  logic [GADGET_BIT_CNT-1:0] i_effect,
    output logic                      o_grab,
    output logic                      o_ball_damage,
    output logic [SPEED_W-1:0]        o_speedstep,
    output logic [BALL_SIZE_W-1:0]    o_ball_size
);
    localparam int unsigned       TMR_W    = $clog2(EFFECT_FRAMES + 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(EFFECT_FRAMES);
    localparam logic signed [X_W:0] STEP_S = signed'((X_W + 1)'(MAX_STEP));

    logic                   ack_q, ack_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [PLAT_SIZE_W-1:0] psize_q, psize_d;
    logic [SIZE_LVL_W-1:0]  size_lvl_q, size_lvl_d;
    logic [SPEED_W-1:0]     speed_q, speed_d;
    logic [BALL_LVL_W-1:0]  ball_lvl_q, ball_lvl_d;
    logic                   grab_q, grab_d, fire_q, fire_d;
    logic [TMR_W-1:0]       grab_tmr_q, grab_tmr_d, fire_tmr_q, fire_tmr_d;

    logic [PLAT_SIZE_W-1:0] half;
    logic signed [X_W:0]    half_s, lo_s, hi_s, pad_s, cur_s, tgt_s, diff_s, new_s;

    // Clamp the requested X inside the walls, then slew-limit the move toward it.
    always_comb begin
        half   = plat_half(size_lvl_q);
        half_s = signed'((X_W + 1)'(half));
        lo_s   = signed'((X_W + 1)'(WALL_THICKNESS)) + half_s;
        hi_s   = signed'((X_W + 1)'(SCREEN_W - WALL_THICKNESS)) - half_s;
        pad_s  = signed'({1'b0, i_gamepad_x});
        cur_s  = signed'({1'b0, x_q});
        tgt_s  = pad_s;
        if (pad_s < lo_s) begin
            tgt_s = lo_s;
        end else if (pad_s > hi_s) begin
            tgt_s = hi_s;
        end
        diff_s = tgt_s - cur_s;
        new_s  = tgt_s;
        if (MAX_STEP != 0) begin
            if (diff_s > STEP_S) begin
                new_s = cur_s + STEP_S;
            end else if (diff_s < -STEP_S) begin
                new_s = cur_s - STEP_S;
            end
        end
    end

    // Next state: frame countdown first so a same-cycle catch reload overrides it.
    always_comb begin
        ack_d      = i_req & ~ack_q;
        x_d        = x_q;
        psize_d    = psize_q;
        size_lvl_d = size_lvl_q;
        speed_d    = speed_q;
        ball_lvl_d = ball_lvl_q;
        grab_d     = grab_q;
        fire_d     = fire_q;
        grab_tmr_d = grab_tmr_q;
        fire_tmr_d = fire_tmr_q;

        if (i_cal_frame) begin
            if (grab_tmr_q != '0) begin
                grab_tmr_d = grab_tmr_q - TMR_W'(1);
                if (grab_tmr_q == TMR_W'(1)) grab_d = 1'b0;
            end
            if (fire_tmr_q != '0) begin
                fire_tmr_d = fire_tmr_q - TMR_W'(1);
                if (fire_tmr_q == TMR_W'(1)) fire_d = 1'b0;
            end
        end

        if (i_catch) begin
            case (i_effect)
                GadgetExpand:
                    if (size_lvl_q < SIZE_LVL_MAX) size_lvl_d = size_lvl_q + 3'd1;
                GadgetShrink:
                    if (size_lvl_q > SIZE_LVL_MIN) size_lvl_d = size_lvl_q - 3'd1;
                GadgetFasterBall:
                    if (speed_q < SPEED_MAX) speed_d = speed_q + 3'd1;
                GadgetSlowerBall:
                    if (speed_q > SPEED_MIN) speed_d = speed_q - 3'd1;
                GadgetBiggerBall:
                    if (ball_lvl_q < BALL_LVL_MAX) ball_lvl_d = ball_lvl_q + 2'd1;
                GadgetSmallerBall:
                    if (ball_lvl_q > BALL_LVL_MIN) ball_lvl_d = ball_lvl_q - 2'd1;
                GadgetGrab: begin
                    grab_d     = 1'b1;
                    grab_tmr_d = TMR_LOAD;
                end
                GadgetFireBall: begin
                    fire_d     = 1'b1;
                    fire_tmr_d = TMR_LOAD;
                end
                default: ;
            endcase
        end

        if (ack_d) begin
            x_d     = X_W'(new_s);
            psize_d = half;
        end

        // Life lost / new game: everything but the position returns to defaults.
        if (i_game_start) begin
            ack_d      = 1'b0;
            x_d        = x_q;
            psize_d    = plat_half(SIZE_LVL_RST);
            size_lvl_d = SIZE_LVL_RST;
            speed_d    = SPEED_RST;
            ball_lvl_d = BALL_LVL_RST;
            grab_d     = 1'b0;
            fire_d     = 1'b0;
            grab_tmr_d = '0;
            fire_tmr_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= 1'b0;
            x_q        <= X_W'(RESET_X);
            psize_q    <= plat_half(SIZE_LVL_RST);
            size_lvl_q <= SIZE_LVL_RST;
            speed_q    <= SPEED_RST;
            ball_lvl_q <= BALL_LVL_RST;
            grab_q     <= 1'b0;
            fire_q     <= 1'b0;
            grab_tmr_q <= '0;
            fire_tmr_q <= '0;
        end else begin
            ack_q      <= ack_d;
            x_q        <= x_d;
            psize_q    <= psize_d;
            size_lvl_q <= size_lvl_d;
            speed_q    <= speed_d;
            ball_lvl_q <= ball_lvl_d;
            grab_q     <= grab_d;
            fire_q     <= fire_d;
            grab_tmr_q <= grab_tmr_d;
            fire_tmr_q <= fire_tmr_d;
        end
    end

    assign o_ack         = ack_q;
    assign o_x           = x_q;
    assign o_size        = psize_q;
    assign o_grab        = grab_q;
    assign o_ball_damage = fire_q;
    assign o_speedstep   = speed_q;
    assign o_ball_size   = ball_radius(ball_lvl_q);

endmodule

// File: rtl/platform_array.sv
// Array of independent platform channels; decodes the catching platform and packs buses.
module platform_array
    import platform_array_pkg::*;
#(
    parameter int unsigned NUM_PLAT      = 2,
    parameter int unsigned X_W           = 10,
    parameter int unsigned EFFECT_FRAMES = 600,
    parameter int unsigned MAX_STEP      = 16,
    localparam int unsigned PLAT_IDX_W   = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_game_start,
    input  logic                            i_cal_frame,
    input  logic [NUM_PLAT*X_W-1:0]         i_gamepad_X,
    input  logic [NUM_PLAT-1:0]             i_plat_req,
    output logic [NUM_PLAT-1:0]             o_plat_ack,
    output logic [NUM_PLAT*X_W-1:0]         o_platX,
    output logic [NUM_PLAT*PLAT_SIZE_W-1:0] o_plat_size,
    input  logic                            i_gadget_valid,
    input  logic [PLAT_IDX_W-1:0]           i_gadget_plat,
    input  logic [GADGET_BIT_CNT-1:0]       i_gadget_effect,
    output logic [NUM_PLAT-1:0]             o_grab,
    output logic [NUM_PLAT-1:0]             o_ball_damage,
    output logic [NUM_PLAT*SPEED_W-1:0]     o_ball_speedstep,
    output logic [NUM_PLAT*BALL_SIZE_W-1:0] o_ball_size
);

    // Index values with no matching platform produce no catch strobe at all.
    for (genvar p = 0; p < NUM_PLAT; p++) begin : g_plat
        logic catch_p;
        assign catch_p = i_gadget_valid && (i_gadget_plat == PLAT_IDX_W'(p));

        platform_channel #(
            .X_W           (X_W),
            .EFFECT_FRAMES (EFFECT_FRAMES),
            .MAX_STEP      (MAX_STEP)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_game_start  (i_game_start),
            .i_cal_frame   (i_cal_frame),
            .i_gamepad_x   (i_gamepad_X[p*X_W +: X_W]),
            .i_req         (i_plat_req[p]),
            .o_ack         (o_plat_ack[p]),
            .o_x           (o_platX[p*X_W +: X_W]),
            .o_size        (o_plat_size[p*PLAT_SIZE_W +: PLAT_SIZE_W]),
            .i_catch       (catch_p),
            .i_effect      (i_gadget_effect),
            .o_grab        (o_grab[p]),
            .o_ball_damage (o_ball_damage[p]),
            .o_speedstep   (o_ball_speedstep[p*SPEED_W +: SPEED_W]),
            .o_ball_size   (o_ball_size[p*BALL_SIZE_W +: BALL_SIZE_W])
        );
    end

endmodule
